// File: rtl/fp_cvt_f2i_pipe.sv
// Three-stage binary32 -> XLEN-bit integer converter (unpack/align, round, range-check/saturate).
// The whole pipe advances as one unit; a stalled result holds every stage.
module fp_cvt_f2i_pipe #(
    parameter int XLEN  = 32,
    parameter int RISCV = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic            in_op,
    input  logic [2:0]      in_rm,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_flags
);
    localparam int AW = XLEN + 25;
    localparam logic [XLEN:0] HALF = {2'b01, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} rm_e;

    logic [3:1] vld_pipe;
    logic       adv;

    assign adv       = ~vld_pipe[3] | out_ready;
    assign in_ready  = adv & ~flush;
    assign out_valid = vld_pipe[3] & ~flush;

    // S1: classify and align; the fixed point sits 24 bits up so G/R/S fall out of the low bits
    logic [7:0]        exp_f;
    logic [22:0]       frac;
    logic [23:0]       sig;
    logic signed [9:0] e;
    logic              is_nan, is_inf, e_big, e_small;
    logic [6:0]        sh;
    logic [AW-1:0]     aligned;

    always_comb begin
        exp_f   = in_data[30:23];
        frac    = in_data[22:0];
        sig     = {|exp_f, frac};
        e       = $signed({2'b00, exp_f}) - 10'sd127;
        is_inf  = (&exp_f) & ~(|frac);
        is_nan  = (&exp_f) & (|frac);
        e_big   = int'(e) > XLEN;
        e_small = int'(e) < -1;
        sh      = (e_big | e_small) ? 7'd0 : 7'(e + 10'sd1);
        aligned = {{(AW-24){1'b0}}, sig} << sh;
    end

    logic            s1_sign, s1_op, s1_g, s1_r, s1_s, s1_nan, s1_inf, s1_oor;
    rm_e             s1_rm;
    logic [XLEN:0]   s1_int;

    // S2: rounding increment
    logic nx, up;
    always_comb begin
        nx = s1_g | s1_r | s1_s;
        case (s1_rm)
            RNE:     up = s1_g & (s1_int[0] | s1_r | s1_s);
            RDN:     up = s1_sign & nx;
            RUP:     up = ~s1_sign & nx;
            RMM:     up = s1_g;
            default: up = 1'b0;
        endcase
    end

    logic            s2_sign, s2_op, s2_nx, s2_nan, s2_inf, s2_oor;
    logic [XLEN:0]   s2_mag;

    // S3: range check and saturation
    logic            oor, invalid;
    logic [XLEN:0]   neg_mag;
    logic [XLEN-1:0] sat, res;
    logic [4:0]      flags;

    always_comb begin
        if (!s2_op) oor = s2_sign ? (s2_mag > HALF) : (s2_mag >= HALF);
        else        oor = s2_sign ? (|s2_mag) : s2_mag[XLEN];
        invalid = oor | s2_oor | s2_inf | s2_nan;
        neg_mag = ~s2_mag + {{XLEN{1'b0}}, 1'b1};
        if (RISCV == 0)
            sat = s2_op ? '1 : {1'b1, {(XLEN-1){1'b0}}};
        else if (s2_nan | ~s2_sign)
            sat = s2_op ? '1 : {1'b0, {(XLEN-1){1'b1}}};
        else
            sat = s2_op ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        res   = invalid ? sat : (s2_sign ? neg_mag[XLEN-1:0] : s2_mag[XLEN-1:0]);
        flags = invalid ? 5'b10000 : {4'b0000, s2_nx};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe   <= '0;
            s1_sign    <= 1'b0; s1_op <= 1'b0; s1_rm <= RNE; s1_int <= '0;
            s1_g       <= 1'b0; s1_r  <= 1'b0; s1_s  <= 1'b0;
            s1_nan     <= 1'b0; s1_inf <= 1'b0; s1_oor <= 1'b0;
            s2_sign    <= 1'b0; s2_op <= 1'b0; s2_nx <= 1'b0; s2_mag <= '0;
            s2_nan     <= 1'b0; s2_inf <= 1'b0; s2_oor <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (flush)    vld_pipe <= '0;
            else if (adv) vld_pipe <= {vld_pipe[2:1], in_valid};
            if (adv) begin
                s1_sign    <= in_data[31];
                s1_op      <= in_op;
                s1_rm      <= (in_rm > 3'd4) ? RTZ : rm_e'(in_rm);
                s1_int     <= e_small ? '0 : aligned[AW-1:24];
                s1_g       <= ~e_small & aligned[23];
                s1_r       <= ~e_small & aligned[22];
                s1_s       <= e_small ? (|sig) : (|aligned[21:0]);
                s1_nan     <= is_nan;
                s1_inf     <= is_inf;
                s1_oor     <= e_big;
                s2_sign    <= s1_sign;
                s2_op      <= s1_op;
                s2_nx      <= nx;
                s2_mag     <= s1_int + {{XLEN{1'b0}}, up};
                s2_nan     <= s1_nan;
                s2_inf     <= s1_inf;
                s2_oor     <= s1_oor;
                out_result <= res;
                out_flags  <= flags;
            end
        end
    end
endmodule

// File: tb/tb_fp_cvt_f2i_pipe.sv
// Bench for fp_cvt_f2i_pipe: three configurations driven in lockstep and checked
// against an arithmetic model of float-to-integer conversion.
module tb_fp_cvt_f2i_pipe;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, in_op = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_rm = '0;
    logic        rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c;
    logic [31:0] res_a, res_b;
    logic [63:0] res_c;
    logic [4:0]  flg_a, flg_b, flg_c;
    int          n_chk = 0, n_fail = 0;

    always #5 clock = ~clock;

    fp_cvt_f2i_pipe #(.XLEN(32), .RISCV(1)) dut_a (.clock(clock), .reset(reset), .in_valid(in_valid),
        .in_ready(rdy_a), .in_data(in_data), .in_op(in_op), .in_rm(in_rm), .flush(flush),
        .out_valid(vld_a), .out_ready(out_ready), .out_result(res_a), .out_flags(flg_a));
    fp_cvt_f2i_pipe #(.XLEN(32), .RISCV(0)) dut_b (.clock(clock), .reset(reset), .in_valid(in_valid),
        .in_ready(rdy_b), .in_data(in_data), .in_op(in_op), .in_rm(in_rm), .flush(flush),
        .out_valid(vld_b), .out_ready(out_ready), .out_result(res_b), .out_flags(flg_b));
    fp_cvt_f2i_pipe #(.XLEN(64), .RISCV(1)) dut_c (.clock(clock), .reset(reset), .in_valid(in_valid),
        .in_ready(rdy_c), .in_data(in_data), .in_op(in_op), .in_rm(in_rm), .flush(flush),
        .out_valid(vld_c), .out_ready(out_ready), .out_result(res_c), .out_flags(flg_c));

    // Value = m * 2^k exactly; quotient/remainder against half decides rounding.
    function automatic void model(input logic [31:0] f, input logic op, input logic [2:0] rm,
                                  input int xlen, input bit riscv,
                                  output logic [63:0] res, output logic [4:0] flg);
        logic s;
        int ex, k, rmode;
        logic [127:0] m, q, r, h, mag, v, mask, half_rng;
        bit nan, inf, huge, nx, above, tie, up, bad;
        s = f[31]; ex = int'(f[30:23]);
        nan = 0; inf = 0; huge = 0; nx = 0; above = 0; tie = 0; q = '0;
        mask = (128'd1 << xlen) - 128'd1;
        half_rng = 128'd1 << (xlen - 1);
        rmode = (rm > 3'd4) ? 1 : int'(rm);
        if (ex == 255) begin
            nan = (f[22:0] != 0); inf = !nan;
        end else begin
            m = (ex == 0) ? {105'd0, f[22:0]} : {105'd1, f[22:0]};
            k = ((ex == 0) ? 1 : ex) - 150;
            if (k > 60) huge = 1;
            else if (k >= 0) q = m << k;
            else if (k < -30) nx = (m != 0);
            else begin
                q = m >> (-k); r = m - (q << (-k)); h = 128'd1 << (-k - 1);
                nx = (r != 0); above = (r > h); tie = (r == h);
            end
        end
        case (rmode)
            0: up = above | (tie & q[0]);
            2: up = s & nx;
            3: up = !s & nx;
            4: up = above | tie;
            default: up = 0;
        endcase
        mag = q + 128'(up);
        if (!op) bad = s ? (mag > half_rng) : (mag > half_rng - 128'd1);
        else     bad = s ? (mag != 0) : (mag > mask);
        bad = bad | nan | inf | huge;
        if (bad) begin
            flg = 5'b10000;
            if (!riscv)          v = op ? mask : half_rng;
            else if (nan || !s)  v = op ? mask : half_rng - 128'd1;
            else                 v = op ? 128'd0 : half_rng;
        end else begin
            flg = {4'b0000, nx};
            v = s ? (128'd0 - mag) : mag;
        end
        res = 64'(v & mask);
    endfunction

    task automatic xfer(input logic [31:0] d, input logic op, input logic [2:0] rm, output int lat);
        int w;
        @(negedge clock);
        in_valid = 1'b1; in_data = d; in_op = op; in_rm = rm; out_ready = 1'b1;
        #1; w = 0;
        while (!rdy_a && w < 20) begin @(negedge clock); #1; w++; end
        @(negedge clock);
        in_valid = 1'b0; lat = 1;
        while (!vld_a && lat < 20) begin @(negedge clock); lat++; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock); #1;
        n_chk++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", vld_a); end
        n_chk++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", rdy_a); end
        n_chk++; if (res_a !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", res_a); end
        n_chk++; if (flg_a !== 5'h0) begin n_fail++; $display("FAIL reset_flags: got %h want 0", flg_a); end
        n_chk++; if (res_c !== 64'h0) begin n_fail++; $display("FAIL reset_result64: got %h want 0", res_c); end
    endtask

    task automatic test_directed();
        logic [31:0] td [13] = '{32'h3FC00000, 32'hC0200000, 32'hC0200000, 32'hC0200000, 32'hC0200000,
                                 32'h7FC00000, 32'h4F000000, 32'h4F000000, 32'hCF000000, 32'hBF800000,
                                 32'hBE99999A, 32'h5F000000, 32'h3FC00000};
        logic        to [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0};
        logic [2:0]  tr [13] = '{0, 0, 4, 1, 2, 0, 0, 0, 0, 0, 1, 0, 7};
        logic [31:0] ta [13] = '{32'h2, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFD,
                                 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h0,
                                 32'h0, 32'hFFFFFFFF, 32'h1};
        logic [4:0]  tf [13] = '{5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h10, 5'h10, 5'h00, 5'h00, 5'h10,
                                 5'h01, 5'h10, 5'h01};
        logic [63:0] eb, ec;
        logic [4:0]  fb, fc;
        int lat;
        for (int i = 0; i < 13; i++) begin
            xfer(td[i], to[i], tr[i], lat);
            model(td[i], to[i], tr[i], 32, 0, eb, fb);
            model(td[i], to[i], tr[i], 64, 1, ec, fc);
            n_chk++; if (lat != 3) begin n_fail++; $display("FAIL latency[%0d]: got %0d want 3", i, lat); end
            n_chk++; if (res_a !== ta[i] || flg_a !== tf[i]) begin n_fail++;
                $display("FAIL dir_a[%0d] %h: got %h/%h want %h/%h", i, td[i], res_a, flg_a, ta[i], tf[i]); end
            n_chk++; if (res_b !== eb[31:0] || flg_b !== fb) begin n_fail++;
                $display("FAIL dir_b[%0d] %h: got %h/%h want %h/%h", i, td[i], res_b, flg_b, eb[31:0], fb); end
            n_chk++; if (res_c !== ec || flg_c !== fc) begin n_fail++;
                $display("FAIL dir_c[%0d] %h: got %h/%h want %h/%h", i, td[i], res_c, flg_c, ec, fc); end
            if (i == 5) begin
                n_chk++; if (res_b !== 32'h80000000 || flg_b !== 5'h10) begin n_fail++;
                    $display("FAIL nan_legacy: got %h/%h want 80000000/10", res_b, flg_b); end
            end
            if (i == 11) begin
                n_chk++; if (res_c !== 64'h8000000000000000 || flg_c !== 5'h00) begin n_fail++;
                    $display("FAIL u64_edge: got %h/%h want 8000000000000000/00", res_c, flg_c); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ops [6];
        logic [63:0] e;
        logic [4:0]  f;
        int sent = 0, got = 0;
        bit extra = 0;
        for (int i = 0; i < 6; i++) ops[i] = {1'($urandom), 8'($urandom_range(120, 160)), 23'($urandom)};
        in_op = 1'b0; in_rm = 3'd0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clock);
            if (cyc == 5) begin
                n_chk++; if (sent != 3) begin n_fail++; $display("FAIL bp_accepted: got %0d want 3", sent); end
            end
            in_valid = (sent < 6); in_data = ops[sent % 6]; out_ready = (cyc >= 5);
            #1;
            if (cyc == 4) begin
                n_chk++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", rdy_a); end
            end
            if (vld_a && out_ready) begin
                model(ops[got], 1'b0, 3'd0, 32, 1, e, f);
                n_chk++; if (res_a !== e[31:0] || flg_a !== f) begin n_fail++;
                    $display("FAIL bp_result[%0d]: got %h/%h want %h/%h", got, res_a, flg_a, e[31:0], f); end
                got++;
            end
            if (in_valid && rdy_a) sent++;
        end
        in_valid = 1'b0;
        repeat (4) begin @(negedge clock); if (vld_a) extra = 1; end
        n_chk++; if (got != 6 || extra) begin n_fail++; $display("FAIL bp_count: got %0d extra %0d want 6 extra 0", got, extra); end
    endtask

    task automatic test_flush();
        logic [63:0] e;
        logic [4:0]  f;
        logic [31:0] d;
        bit seen = 0;
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_data = 32'h40400000 + 32'(i); in_op = 1'b0; in_rm = 3'd0; out_ready = 1'b1;
        end
        @(negedge clock);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h41000000;
        #1;
        n_chk++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", rdy_a); end
        n_chk++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", vld_a); end
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        repeat (6) begin #1; if (vld_a) seen = 1; @(negedge clock); end
        n_chk++; if (seen) begin n_fail++; $display("FAIL flush_kill: got out_valid 1 want 0"); end
        d = 32'hC2F6E666;
        xfer(d, 1'b0, 3'd3, lat);
        model(d, 1'b0, 3'd3, 32, 1, e, f);
        n_chk++; if (lat != 3) begin n_fail++; $display("FAIL flush_latency: got %0d want 3", lat); end
        n_chk++; if (res_a !== e[31:0] || flg_a !== f) begin n_fail++;
            $display("FAIL flush_result: got %h/%h want %h/%h", res_a, flg_a, e[31:0], f); end
    endtask

    task automatic test_random();
        logic [31:0] qd[$];
        logic        qo[$];
        logic [2:0]  qr[$];
        logic [31:0] d, pd, last_a;
        logic        po;
        logic [2:0]  pr;
        logic [63:0] ea, eb, ec;
        logic [4:0]  fa, fb, fc;
        logic        held = 1'b0;
        int sent = 0, got = 0, cyc = 0;
        while (got < 300 && cyc < 5000) begin
            @(negedge clock);
            if (held) begin
                n_chk++; if (res_a !== last_a) begin n_fail++; $display("FAIL hold: got %h want %h", res_a, last_a); end
            end
            d = $urandom;
            case ($urandom_range(0, 7))
                0:       d[30:23] = 8'hFF;
                1:       d[30:23] = 8'h00;
                default: d[30:23] = 8'($urandom_range(100, 192));
            endcase
            if ($urandom_range(0, 3) == 0) d[15:0] = '0;
            in_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
            in_data = d; in_op = 1'($urandom); in_rm = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (vld_a && out_ready) begin
                if (qd.size() == 0) begin
                    n_chk++; n_fail++; $display("FAIL rnd_spurious: got out_valid 1 want 0");
                end else begin
                    pd = qd.pop_front(); po = qo.pop_front(); pr = qr.pop_front();
                    model(pd, po, pr, 32, 1, ea, fa);
                    model(pd, po, pr, 32, 0, eb, fb);
                    model(pd, po, pr, 64, 1, ec, fc);
                    n_chk++; if (res_a !== ea[31:0] || flg_a !== fa) begin n_fail++;
                        $display("FAIL rnd_a %h op%0d rm%0d: got %h/%h want %h/%h", pd, po, pr, res_a, flg_a, ea[31:0], fa); end
                    n_chk++; if (res_b !== eb[31:0] || flg_b !== fb) begin n_fail++;
                        $display("FAIL rnd_b %h op%0d rm%0d: got %h/%h want %h/%h", pd, po, pr, res_b, flg_b, eb[31:0], fb); end
                    n_chk++; if (res_c !== ec || flg_c !== fc) begin n_fail++;
                        $display("FAIL rnd_c %h op%0d rm%0d: got %h/%h want %h/%h", pd, po, pr, res_c, flg_c, ec, fc); end
                    got++;
                end
            end
            held = vld_a && !out_ready;
            last_a = res_a;
            if (in_valid && rdy_a) begin qd.push_back(d); qo.push_back(in_op); qr.push_back(in_rm); sent++; end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_chk++; if (got != 300) begin n_fail++; $display("FAIL rnd_count: got %0d want 300", got); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            in_valid = 1'b1; in_data = 32'h42280000; in_op = 1'b0; in_rm = 3'd0; out_ready = 1'b1;
        end
        @(negedge clock);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; #1;
        n_chk++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", vld_a); end
        n_chk++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", rdy_a); end
        repeat (5) begin @(negedge clock); if (vld_a) seen = 1; end
        n_chk++; if (seen) begin n_fail++; $display("FAIL rstmid_discard: got out_valid 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_cvt_f2i_pipe.md
Name: fp_cvt_f2i_pipe

Overview:
Pipelined binary32-to-integer converter, parametrised successor of the combinational float-to-int path. Supports 32- or 64-bit integer results, signed/unsigned, all five IEEE rounding modes, and selectable saturation semantics. It sits between the FPU issue stage and the integer writeback. Valid/ready handshakes on both sides, full backpressure and flush.

Parameters:
XLEN, 32, integer result width; legal values 32 or 64.
RISCV, 0, saturation mode. 0 = legacy: any invalid gives the signed minimum / unsigned all-ones. 1 = RISC-V: NaN gives the maximum, and directional saturation applies.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input operand valid
in_ready  out  1  converter can accept this cycle
in_data  in  32  IEEE binary32 operand
in_op  in  1  0 = signed, 1 = unsigned
in_rm  in  3  0 rne, 1 rtz, 2 rdn, 3 rup, 4 rmm; 5–7 treated as rtz
flush  in  1  kill all in-flight entries
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  XLEN  integer result
out_flags  out  5  {NV,DZ,OF,UF,NX}; only bits 4 and 0 are ever set

Behaviour:
- Handshakes
  - Accept on in_valid & in_ready.
  - Deliver on out_valid & out_ready.
  - in_ready = ~s3_valid | out_ready: the whole pipe advances together and holds on stall.
- Latency: exactly 3 cycles from accept to out_valid when unstalled. Throughput is 1 per cycle.
- S1, unpack and classify:
  - Classify the operand as zero, subnormal, normal, inf, sNaN or qNaN. Subnormals convert with hidden bit 0.
  - Form the significand {hidden, frac} and the unbiased exponent e = exp − 127.
  - If e > XLEN, mark oor and skip the shift.
  - Otherwise align the significand into an XLEN+1-bit integer part plus guard, round and sticky bits using a barrel shift; e < −1 leaves only sticky.
- S2, round:
  - NX = G|R|S.
  - Round-up conditions:
    - rne: G & (lsb|R|S)
    - rdn: sign & NX
    - rup: ~sign & NX
    - rmm: G
  - Add the increment to the XLEN+1-bit magnitude.
- S3, range check and saturate:
  - Let mag be the rounded magnitude.
  - Signed, positive: oor if mag ≥ 2^(XLEN−1).
  - Signed, negative: oor if mag > 2^(XLEN−1).
  - Unsigned, positive: oor if mag ≥ 2^XLEN.
  - Unsigned, negative: oor if mag ≠ 0.
  - Invalid = oor | inf | NaN. Invalid sets flags = 5'b10000 and clears NX.
  - Otherwise flags = {4'b0, NX} and result = sign ? −mag : mag, truncated to XLEN.
- Saturation values, RISCV=0:
  - signed invalid → 1 followed by XLEN−1 zeros
  - unsigned invalid → all ones
- Saturation values, RISCV=1:
  - NaN or positive invalid → signed max 0x7F..F, unsigned all ones
  - negative invalid → signed min 0x80..0, unsigned 0
- Negative values that round to magnitude 0 in unsigned mode are valid: result 0, NX only.
- Reset: clears s1/s2/s3 valid bits. out_valid = 0, in_ready = 1 the cycle after reset. out_result and out_flags are zeroed and datapath regs are zeroed. Reset mid-operation discards all entries.
- Flush:
  - Clears all stage valids at the next edge.
  - An input presented in the flush cycle is not accepted; in_ready is forced to 0 during flush.
  - Flush has priority over out_ready.
- out_result and out_flags hold stable while out_valid & ~out_ready.

Test Plan:
- XLEN=32, RISCV=1, 0x3FC00000 (1.5), signed, rne → 0x00000002, flags 0x01, out_valid exactly 3 cycles after accept.
- 0xC0200000 (−2.5), signed: rne → 0xFFFFFFFE, flags 0x01; rmm → 0xFFFFFFFD; rtz → 0xFFFFFFFE; rdn → 0xFFFFFFFD.
- NaN 0x7FC00000, signed: RISCV=1 → 0x7FFFFFFF, flags 0x10; RISCV=0 → 0x80000000, flags 0x10.
- Range edges, RISCV=1:
  - 0x4F000000 (2^31) signed → 0x7FFFFFFF, NV.
  - Same value unsigned → 0x80000000, flags 0.
  - 0xCF000000 signed → 0x80000000, flags 0.
  - 0xBF800000 (−1.0) unsigned → 0x00000000, NV.
  - 0xBE99999A (−0.3) unsigned rtz → 0, flags 0x01.
  - XLEN=64: 0x5F000000 unsigned → 0x8000000000000000, flags 0.
- Backpressure: stream 6 operands with out_ready low for 5 cycles → exactly 3 (pipeline capacity) plus 0 extra accepted, in_ready low while stalled, all 6 results in order, no duplicates or drops.
- Flush and reset:
  - Assert flush with 3 entries in flight → no out_valid for those entries; the next accepted operand emerges 3 cycles later.
  - Assert reset mid-stream → out_valid = 0 next cycle.
